// File: rtl/sram_mem_stage.sv
// sram_mem_stage: ARM pipeline MEM stage splitting word accesses into waited SRAM beats.
// Define MEM_STAGE_RD_BYPASS_EN to add a one-entry last-read bypass buffer.
module sram_mem_stage #(
   parameter int WORD_W      = 32,
   parameter int SRAM_DW     = 16,
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_BASE   = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic               wb_en,
   input  logic [WORD_W-1:0]  alu_res,
   input  logic [WORD_W-1:0]  val_rm,
   input  logic [3:0]         dest,
   output logic               mem_r_en_out,
   output logic               wb_en_out,
   output logic [WORD_W-1:0]  alu_res_out,
   output logic [3:0]         dest_out,
   output logic [WORD_W-1:0]  mem_data_out,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);
   localparam int BEATS = WORD_W / SRAM_DW;
   localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam int SH    = $clog2(WORD_W / 8);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            st;
   logic [BW-1:0]     beat;
   logic [3:0]        wcnt;
   logic [WORD_W-1:0] rbuf, rbuf_nxt, word, hit_data;
   logic              wr, rd, req, hit, beat_end, last;

   assign wr       = mem_w_en;
   assign rd       = mem_r_en & ~mem_w_en;
   assign req      = mem_r_en | mem_w_en;
   assign word     = (alu_res - WORD_W'(ADDR_BASE)) >> SH;
   assign beat_end = wcnt == 4'(WAIT_CYCLES);
   assign last     = beat_end && beat == BW'(BEATS - 1);

   assign ready        = st == DONE || (st == IDLE && (!req || hit));
   assign mem_r_en_out = rd & ready;
   assign wb_en_out    = wb_en;
   assign alu_res_out  = alu_res;
   assign dest_out     = dest;

   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_ADDR = st == ACCESS ? SRAM_AW'(word * WORD_W'(BEATS) + WORD_W'(beat)) : '0;
   // The final cycle of each write beat keeps data on the bus with WE_N raised for hold time.
   assign SRAM_WE_N = !(st == ACCESS && wr && (WAIT_CYCLES == 0 || !beat_end));
   assign SRAM_DQ   = (st == ACCESS && wr) ? val_rm[int'(beat)*SRAM_DW +: SRAM_DW] : 'z;

   always_comb begin
      rbuf_nxt = rbuf;
      rbuf_nxt[int'(beat)*SRAM_DW +: SRAM_DW] = SRAM_DQ;
   end

`ifdef MEM_STAGE_RD_BYPASS_EN
   logic              bvalid;
   logic [WORD_W-1:0] baddr, bdata;

   assign hit      = st == IDLE && rd && bvalid && baddr == word;
   assign hit_data = bdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bvalid <= 1'b0;
         baddr  <= '0;
         bdata  <= '0;
      end else if (st == ACCESS && last && rd) begin
         bvalid <= 1'b1;
         baddr  <= word;
         bdata  <= rbuf_nxt;
      end else if (st == DONE && wr && bvalid && baddr == word) begin
         bdata  <= val_rm;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st           <= IDLE;
         beat         <= '0;
         wcnt         <= '0;
         rbuf         <= '0;
         mem_data_out <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (hit) mem_data_out <= hit_data;
               else if (req) begin
                  st   <= ACCESS;
                  beat <= '0;
                  wcnt <= '0;
               end
            end
            ACCESS: begin
               if (!beat_end) wcnt <= wcnt + 4'd1;
               else begin
                  wcnt <= '0;
                  if (rd) rbuf <= rbuf_nxt;
                  // Load data is published on entry to DONE so it is visible while ready is high.
                  if (last) begin
                     st <= DONE;
                     if (rd) mem_data_out <= rbuf_nxt;
                  end else beat <= beat + BW'(1);
               end
            end
            DONE: begin
               st   <= IDLE;
               beat <= '0;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_mem_stage.sv
// tb_sram_mem_stage: table-driven check of sram_mem_stage with a small SRAM model.
module tb_sram_mem_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef MEM_STAGE_RD_BYPASS_EN
   localparam int HITLOW = 0;
`else
   localparam int HITLOW = 5;
`endif

   logic        mem_r_en = 0, mem_w_en = 0, wb_en = 0;
   logic [31:0] alu_res = 0, val_rm = 0;
   logic [3:0]  dest = 0;
   logic        mem_r_en_out, wb_en_out, ready;
   logic [31:0] alu_res_out, mem_data_out;
   logic [3:0]  dest_out;
   wire  [15:0] dq;
   logic [17:0] sram_addr;
   logic        ub_n, lb_n, we_n, ce_n, oe_n;
   logic        z_probe = 0;
   logic [15:0] mem [0:63];
   logic        drv;
   logic [15:0] drv_val;

   assign drv     = z_probe | (mem_r_en & ~mem_w_en & we_n);
   assign drv_val = z_probe ? 16'hA5A5 : mem[sram_addr[5:0]];
   assign dq      = drv ? drv_val : 16'bz;

   always @(posedge clk) if (!we_n) mem[sram_addr[5:0]] <= dq;

   sram_mem_stage dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
      .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .mem_r_en_out(mem_r_en_out),
      .wb_en_out(wb_en_out), .alu_res_out(alu_res_out), .dest_out(dest_out),
      .mem_data_out(mem_data_out), .ready(ready), .SRAM_DQ(dq), .SRAM_ADDR(sram_addr),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
   );

   logic        w3 = 0;
   logic        r3o, wb3o, ready3, ub3, lb3, we3, ce3, oe3;
   logic [31:0] alu3o, data3o;
   logic [3:0]  dest3o;
   wire  [15:0] dq3;
   logic [17:0] addr3;

   sram_mem_stage #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .mem_r_en(1'b0), .mem_w_en(w3), .wb_en(1'b0),
      .alu_res(32'd1032), .val_rm(32'h0BADF00D), .dest(4'd0), .mem_r_en_out(r3o),
      .wb_en_out(wb3o), .alu_res_out(alu3o), .dest_out(dest3o),
      .mem_data_out(data3o), .ready(ready3), .SRAM_DQ(dq3), .SRAM_ADDR(addr3),
      .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_WE_N(we3), .SRAM_CE_N(ce3), .SRAM_OE_N(oe3)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        r, w, wb;
      logic [31:0] addr, data;
      logic [3:0]  dst;
      int          low, we;
      logic        rd_out;
      logic [31:0] dout;
   } vec_t;

   vec_t tv [11];

   task automatic run(input vec_t v);
      int low = 0;
      int we  = 0;
      mem_r_en = v.r; mem_w_en = v.w; wb_en = v.wb;
      alu_res = v.addr; val_rm = v.data; dest = v.dst;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (ready) break;
         low++;
         if (!we_n) we++;
      end
      chk("ready_low", low, v.low);
      chk("we_low", we, v.we);
      chk("rd_out", {31'd0, mem_r_en_out}, {31'd0, v.rd_out});
      chk("pass", {wb_en_out, dest_out, alu_res_out}, {v.wb, v.dst, v.addr});
      @(posedge clk); #1;
      mem_r_en = 0; mem_w_en = 0; wb_en = 0;
      chk("dout", mem_data_out, v.dout);
   endtask

   initial begin
      int n;
      tv[0]  = '{0, 1, 0, 32'd1024, 32'hDEADBEEF, 4'd3, 5, 2, 0, 32'h0};
      tv[1]  = '{1, 0, 1, 32'd1024, 32'h0,        4'd5, 5, 0, 1, 32'hDEADBEEF};
      tv[2]  = '{0, 0, 1, 32'h55,   32'h0,        4'd7, 0, 0, 0, 32'hDEADBEEF};
      tv[3]  = '{0, 1, 0, 32'd1028, 32'hCAFEF00D, 4'd1, 5, 2, 0, 32'hDEADBEEF};
      tv[4]  = '{1, 0, 1, 32'd1028, 32'h0,        4'd2, 5, 0, 1, 32'hCAFEF00D};
      tv[5]  = '{1, 1, 1, 32'd1032, 32'h0BADC0DE, 4'd4, 5, 2, 0, 32'hCAFEF00D};
      tv[6]  = '{1, 0, 1, 32'd1032, 32'h0,        4'd6, 5, 0, 1, 32'h0BADC0DE};
      tv[7]  = '{1, 0, 1, 32'd1032, 32'h0,        4'd6, HITLOW, 0, 1, 32'h0BADC0DE};
      tv[8]  = '{1, 0, 1, 32'd1024, 32'h0,        4'd8, 5, 0, 1, 32'hDEADBEEF};
      tv[9]  = '{0, 1, 0, 32'd1024, 32'h12345678, 4'd9, 5, 2, 0, 32'hDEADBEEF};
      tv[10] = '{1, 0, 1, 32'd1024, 32'h0,        4'd10, HITLOW, 0, 1, 32'h12345678};

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_we_n", {31'd0, we_n}, 32'd1);
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);
      chk("rst_dout", mem_data_out, 32'd0);
      rst = 0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         run(tv[i]);
         if (i == 0) begin
            chk("sram0", {16'd0, mem[0]}, 32'h0000BEEF);
            chk("sram1", {16'd0, mem[1]}, 32'h0000DEAD);
         end
      end
      chk("sram0_final", {16'd0, mem[0]}, 32'h5678);
      chk("sram1_final", {16'd0, mem[1]}, 32'h1234);
      chk("sram2", {16'd0, mem[2]}, 32'hF00D);
      chk("sram3", {16'd0, mem[3]}, 32'hCAFE);
      chk("sram4", {16'd0, mem[4]}, 32'hC0DE);
      chk("sram5", {16'd0, mem[5]}, 32'h0BAD);

      // WAIT_CYCLES=3 instance: beats at word 4 and 5, four cycles each.
      w3 = 1;
      n = 0;
      begin
         int wl = 0;
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready3) break;
            if (!we3) wl++;
            if (n == 1 || n == 4) chk("w3_addr_b0", {14'd0, addr3}, 32'd4);
            if (n == 5 || n == 8) chk("w3_addr_b1", {14'd0, addr3}, 32'd5);
            n++;
         end
         chk("w3_ready_low", n, 9);
         chk("w3_we_low", wl, 6);
      end
      @(posedge clk); #1;
      w3 = 0;

      // Reset in the middle of a write beat.
      mem_w_en = 1; alu_res = 32'd1028; val_rm = 32'h11112222;
      @(negedge clk);
      @(negedge clk);
      chk("mid_we_n", {31'd0, we_n}, 32'd0);
      #2 rst = 1;
      #1 chk("abort_we_n", {31'd0, we_n}, 32'd1);
      z_probe = 1;
      #1 chk("abort_dq_z", {16'd0, dq}, 32'h0000A5A5);
      z_probe = 0;
      mem_w_en = 0;
      #1 chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_dout", mem_data_out, 32'd0);
      chk("abort_addr", {14'd0, sram_addr}, 32'd0);
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
      chk("abort_no_write", {16'd0, mem[2]}, 32'hF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sram_mem_stage.md
Name: sram_mem_stage

Overview:
- Parametrised memory stage for the 5-stage ARM pipeline, between EXE and WB.
- Splits one WORD_W-bit load or store into WORD_W/SRAM_DW sequential SRAM beats.
- Inserts a programmable number of wait cycles per beat.
- Freezes the pipeline via `ready` until the access completes; non-memory instructions pass through with no stall.

Parameters:
- WORD_W, 32, pipeline data width; integer multiple of SRAM_DW.
- SRAM_DW, 16, external SRAM data-bus width.
- SRAM_AW, 18, external SRAM address width.
- WAIT_CYCLES, 1, extra hold cycles per beat (0..15).
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_r_en  in  1  load request from EXE/MEM register.
- mem_w_en  in  1  store request from EXE/MEM register.
- wb_en  in  1  writeback enable, passed through.
- alu_res  in  WORD_W  byte address; also the ALU result passed to WB.
- val_rm  in  WORD_W  store data.
- dest  in  4  destination register, passed through.
- mem_r_en_out  out  1  mem_r_en & ready.
- wb_en_out  out  1  = wb_en.
- alu_res_out  out  WORD_W  = alu_res.
- dest_out  out  4  = dest.
- mem_data_out  out  WORD_W  registered load data.
- ready  out  1  high = stage may advance; low = freeze the pipeline.
- SRAM_DQ  inout  SRAM_DW  SRAM data bus; high-Z unless writing.
- SRAM_ADDR  out  SRAM_AW  SRAM word address.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N  out  1 each  tied low.
- SRAM_WE_N  out  1  active-low write strobe.
- SRAM_OE_N  out  1  tied low.

Behaviour:
- Definitions:
  - BEATS = WORD_W/SRAM_DW.
  - req = mem_r_en | mem_w_en.
  - If both enables are high, the write wins and the read is ignored (mem_r_en_out = 0).
- Reset (async): state=IDLE, beat=0, wait counter=0, mem_data_out=0, SRAM_WE_N=1, SRAM_DQ high-Z, SRAM_ADDR=0.
- Address mapping:
  - word = (alu_res - ADDR_BASE) >> log2(WORD_W/8).
  - SRAM_ADDR = word*BEATS + beat, truncated to SRAM_AW.
  - Beat 0 carries the least-significant SRAM_DW bits.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - ready = ~req.
  - On req → ACCESS with beat=0, wcnt=0.
- ACCESS: each beat lasts WAIT_CYCLES+1 cycles.
  - Write: SRAM_DQ = val_rm slice[beat] for the whole beat. SRAM_WE_N low for all cycles of the beat except the last, which raises it for hold. With WAIT_CYCLES=0, WE_N is low for the single cycle.
  - Read: SRAM_WE_N=1. SRAM_DQ is sampled into internal slice[beat] at the last cycle of the beat.
  - After the last beat's last cycle → DONE.
- DONE:
  - ready=1 for exactly one cycle; mem_data_out is updated from the assembled read buffer (reads only).
  - → IDLE unconditionally.
  - The pipeline advances on this edge, so IDLE sees the next instruction.
- Latency: ready is low for 1 + BEATS*(WAIT_CYCLES+1) cycles, i.e. 5 with defaults.
- Input stability: inputs must be held stable while ready=0 (pipeline frozen); behaviour is undefined otherwise.
- mem_data_out holds its value until the next completed read; writes never change it.
- Reset mid-access aborts immediately: WE_N high, bus released, no partial data latched.
- Address wrap: an SRAM_ADDR overflow wraps modulo 2^SRAM_AW; no error is flagged.

Optional Feature:
- Macro: MEM_STAGE_RD_BYPASS_EN.
- Defined: adds a one-entry last-read buffer (valid bit, word address, data).
  - A read in IDLE hitting a valid entry gives ready=1 in the same cycle, no SRAM cycles, and mem_data_out loaded with the buffered data on that edge.
  - A write to the same word updates the buffered data at DONE.
  - Reset clears valid.
- Undefined: every read goes to SRAM; the buffer logic is absent.

Test Plan:
- Reset: assert rst mid-ACCESS of a write → SRAM_WE_N=1 and SRAM_DQ=Z within the same cycle, ready=1 in IDLE, mem_data_out=0.
- Store then load: write 0xDEADBEEF to 1024 → SRAM_ADDR 0 gets 0xBEEF, addr 1 gets 0xDEAD, ready low 5 cycles. Read 1024 → mem_data_out=0xDEADBEEF in the DONE cycle.
- Address 1032, WAIT_CYCLES=3 → SRAM_ADDR 4 then 5, each beat 4 cycles, ready low 9 cycles.
- Pass-through: mem_r_en=mem_w_en=0, wb_en=1 → ready stays 1, outputs equal inputs, no SRAM activity.
- Simultaneous mem_r_en=mem_w_en=1 → write performed, mem_r_en_out=0, mem_data_out unchanged.
- Bypass (macro defined): read 1024 twice → second completes with ready=1 in its first cycle. Then write 0x12345678 to 1024 and read again → 0x12345678 without SRAM access.
